mat_stream_to_axi_packer: RTL and testbench

//  Output stage of the pre-processing pipeline. Packs a frame of 24-bit pixels from a

---
 rtl/mat_stream_to_axi_packer_if.sv | 33 +++
 rtl/mat_stream_to_axi_packer.sv | 213 +++++++++++++++++++++
 tb/tb_mat_stream_to_axi_packer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_stream_to_axi_packer_if.sv
// Bus bundle for the packer: ap_ctrl_chain control, frame dimensions, upstream
// FIFO read port and downstream FIFO write port.
interface mat_stream_to_axi_packer_if #(
  parameter int PIX_W = 24,
  parameter int AXI_W = 64
);
  // Handshakes: a parameter push happens on a cycle with ap_start & ap_ready;
  // a pixel pop on in_read (only ever with in_empty_n); a word push on
  // out_write (only ever with out_full_n); ap_done holds until ap_continue.
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_continue;
  logic [15:0]      rows;
  logic [31:0]      cols;
  logic [PIX_W-1:0] in_dout;
  logic             in_empty_n;
  logic             in_read;
  logic [AXI_W-1:0] out_din;
  logic             out_full_n;
  logic             out_write;

  modport master (
    output ap_start, ap_continue, rows, cols, in_dout, in_empty_n, out_full_n,
    input  ap_ready, ap_done, ap_idle, in_read, out_din, out_write
  );

  modport slave (
    input  ap_start, ap_continue, rows, cols, in_dout, in_empty_n, out_full_n,
    output ap_ready, ap_done, ap_idle, in_read, out_din, out_write
  );
endinterface

// File: rtl/mat_stream_to_axi_packer.sv
// Packs a row-major frame of PIX_W-bit pixels into a dense little-endian AXI_W-bit
// word stream; frame sizes are queued in a small parameter FIFO ahead of the packer.
module mat_stream_to_axi_packer #(
  parameter int PIX_W   = 24,
  parameter int AXI_W   = 64,
  parameter int PRM_DEP = 3
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  mat_stream_to_axi_packer_if.slave bus,
  output logic [1:0]                dbg_state_o
);
  localparam int FILL_W = $clog2(AXI_W);
  localparam int CNT_W  = $clog2(PRM_DEP + 1);
  localparam int PTR_W  = (PRM_DEP > 1) ? $clog2(PRM_DEP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      prm_rows_q [PRM_DEP];
  logic [31:0]      prm_cols_q [PRM_DEP];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q;
  logic             prm_full, prm_empty, push, pop;
  logic [15:0]      head_rows;
  logic [31:0]      head_cols;

  logic [15:0]            row_rem_q, row_rem_d;
  logic [31:0]            col_rem_q, col_rem_d;
  logic [31:0]            col_len_q, col_len_d;
  logic [AXI_W-1:0]       buf_q, buf_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [FILL_W:0]        fill_sum;
  logic [FILL_W-1:0]      fill_nxt;
  logic                   wd;
  logic [AXI_W+PIX_W-1:0] pix_shift;
  logic [AXI_W-1:0]       merged, carry;
  logic                   last_pix;
  logic                   rd_fire, wr_fire;
  logic [AXI_W-1:0]       dout;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PRM_DEP - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------- parameter FIFO ----------------
  // armed_q keeps ap_ready low while reset is held and for the first cycle after.
  assign prm_full  = (cnt_q == CNT_W'(PRM_DEP));
  assign prm_empty = (cnt_q == '0);
  assign push      = bus.ap_start & armed_q & ~prm_full;
  assign pop       = (state_q == S_IDLE) & ~prm_empty;
  assign head_rows = prm_rows_q[rd_ptr_q];
  assign head_cols = prm_cols_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      armed_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < PRM_DEP; i++) begin
        prm_rows_q[i] <= '0;
        prm_cols_q[i] <= '0;
      end
    end else begin
      armed_q  <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        prm_rows_q[wr_ptr_q] <= bus.rows;
        prm_cols_q[wr_ptr_q] <= bus.cols;
      end
    end
  end

  // ---------------- bit packing ----------------
  // Shifting into a word-plus-pixel wide vector yields both the part that lands in
  // the current word and the spill-over that starts the next one.
  assign fill_sum  = {1'b0, fill_q} + (FILL_W + 1)'(PIX_W);
  assign wd        = (fill_sum >= (FILL_W + 1)'(AXI_W));
  assign fill_nxt  = wd ? FILL_W'(fill_sum - (FILL_W + 1)'(AXI_W)) : FILL_W'(fill_sum);
  assign pix_shift = {{AXI_W{1'b0}}, bus.in_dout} << fill_q;
  assign merged    = buf_q | pix_shift[AXI_W-1:0];
  assign carry     = {{(AXI_W - PIX_W){1'b0}}, pix_shift[AXI_W+PIX_W-1:AXI_W]};
  assign last_pix  = (row_rem_q == 16'd1) && (col_rem_q == 32'd1);

  always_comb begin
    row_rem_d = row_rem_q;
    col_rem_d = col_rem_q;
    col_len_d = col_len_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    if (pop) begin
      row_rem_d = head_rows;
      col_rem_d = head_cols;
      col_len_d = head_cols;
      buf_d     = '0;
      fill_d    = '0;
    end else if (rd_fire) begin
      buf_d  = wd ? carry : merged;
      fill_d = fill_nxt;
      if (col_rem_q == 32'd1) begin
        col_rem_d = col_len_q;
        row_rem_d = row_rem_q - 16'd1;
      end else begin
        col_rem_d = col_rem_q - 32'd1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      row_rem_q <= '0;
      col_rem_q <= '0;
      col_len_q <= '0;
      buf_q     <= '0;
      fill_q    <= '0;
    end else begin
      row_rem_q <= row_rem_d;
      col_rem_q <= col_rem_d;
      col_len_q <= col_len_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
    end
  end

  // ---------------- packer FSM ----------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = ((head_rows == 16'd0) || (head_cols == 32'd0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_fire && last_pix) begin
          state_d = (fill_nxt != '0) ? S_FLUSH : S_DONE;
        end
      end
      S_FLUSH: begin
        if (bus.out_full_n) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ap_continue) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pixel that completes a word may only be taken when the word can be pushed.
  always_comb begin
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    dout    = '0;
    case (state_q)
      S_RUN: begin
        rd_fire = bus.in_empty_n & (~wd | bus.out_full_n);
        if (rd_fire && wd) begin
          wr_fire = 1'b1;
          dout    = merged;
        end
      end
      S_FLUSH: begin
        if (bus.out_full_n) begin
          wr_fire = 1'b1;
          dout    = buf_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_read   = rd_fire;
  assign bus.out_write = wr_fire;
  assign bus.out_din   = dout;
  assign bus.ap_ready  = push;
  assign bus.ap_done   = (state_q == S_DONE);
  assign bus.ap_idle   = (state_q == S_IDLE) & prm_empty;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mat_stream_to_axi_packer.sv
// Bench for mat_stream_to_axi_packer: random pixel/stall stimulus checked against a
// bit-queue packing model of the output stream.
module tb_mat_stream_to_axi_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mat_stream_to_axi_packer_if bus ();

  mat_stream_to_axi_packer dut (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [23:0] pix_q[$];
  bit rand_in  = 1'b0;
  bit rand_out = 1'b0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int viol   = 0;

  // Upstream/downstream FIFO models: drive just after the rising edge, observe at the falling edge.
  initial begin
    bus.in_empty_n = 1'b0;
    bus.in_dout    = '0;
    bus.out_full_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_full_n = rand_out ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pix_q.size() > 0) begin
        bus.in_empty_n = rand_in ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.in_dout    = pix_q[0];
      end else begin
        bus.in_empty_n = 1'b0;
        bus.in_dout    = 24'($urandom);
      end
      @(negedge clk);
      if (bus.in_read) begin
        if (!bus.in_empty_n) viol++;
        else void'(pix_q.pop_front());
        rd_cnt++;
      end
      if (bus.out_write) begin
        if (!bus.out_full_n) viol++;
        got_q.push_back(bus.out_din);
        wr_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: stream the frame's pixels as a flat bit queue, cut every 64 bits.
  task automatic add_frame(input int r, input int c, input bit seq);
    bit          bits[$];
    logic [63:0] w;
    logic [23:0] px;
    for (int p = 0; p < r * c; p++) begin
      px = seq ? 24'(p + 1) : 24'($urandom);
      pix_q.push_back(px);
      for (int b = 0; b < 24; b++) bits.push_back(px[b]);
      while (bits.size() >= 64) begin
        w = '0;
        for (int i = 0; i < 64; i++) w[i] = bits.pop_front();
        exp_q.push_back(w);
      end
    end
    if (bits.size() > 0) begin
      w = '0;
      for (int i = 0; i < bits.size(); i++) w[i] = bits[i];
      exp_q.push_back(w);
    end
  endtask

  // Called and returning just after a rising edge.
  task automatic push_params(input logic [15:0] r, input logic [31:0] c,
                             output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    bus.ap_start = 1'b1;
    bus.rows = r;
    bus.cols = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ap_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
    end
    bus.ap_start = 1'b0;
  endtask

  task automatic finish_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.ap_done) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (ok) begin
      bus.ap_continue = 1'b1;
      @(posedge clk);
      #1;
      bus.ap_continue = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (bus.ap_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ap_ready: got %b want 0", bus.ap_ready); end
    n_checks++; if (bus.ap_done !== 1'b0) begin n_fail++; $display("FAIL reset_ap_done: got %b want 0", bus.ap_done); end
    n_checks++; if (bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_ap_idle: got %b want 1", bus.ap_idle); end
    n_checks++; if (bus.in_read !== 1'b0) begin n_fail++; $display("FAIL reset_in_read: got %b want 0", bus.in_read); end
    n_checks++; if (bus.out_write !== 1'b0) begin n_fail++; $display("FAIL reset_out_write: got %b want 0", bus.out_write); end
    n_checks++; if (bus.out_din !== 64'h0) begin n_fail++; $display("FAIL reset_out_din: got %h want 0", bus.out_din); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_small_frame();
    bit ok;
    int waited, rd0;
    exp_q.delete(); got_q.delete();
    rd0 = rd_cnt;
    add_frame(1, 8, 1'b1);
    push_params(16'd1, 32'd8, ok, waited);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL small_ready: got 0 want 1"); end
    finish_frame(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL small_done: got timeout want ap_done"); end
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL small_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL small_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
      end
    end
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== 64'h0003000002000001) begin
      n_fail++; $display("FAIL small_w0_const: got %h want 0003000002000001", (got_q.size() > 0) ? got_q[0] : 64'hx);
    end
    n_checks++; if (rd_cnt - rd0 != 8) begin n_fail++; $display("FAIL small_reads: got %0d want 8", rd_cnt - rd0); end
  endtask

  task automatic test_single_pixel();
    bit ok;
    int waited;
    exp_q.delete(); got_q.delete();
    pix_q.push_back(24'hABCDEF);
    push_params(16'd1, 32'd1, ok, waited);
    finish_frame(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done: got timeout want ap_done"); end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 64'h0000000000ABCDEF) begin
      n_fail++; $display("FAIL single_word: got n=%0d w=%h want n=1 w=0000000000abcdef",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'hx);
    end
  endtask

  task automatic test_flush_word();
    bit ok;
    int waited;
    exp_q.delete(); got_q.delete();
    add_frame(2, 3, 1'b0);
    push_params(16'd2, 32'd3, ok, waited);
    finish_frame(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_done: got timeout want ap_done"); end
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL flush_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL flush_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
      end
    end
    n_checks++;
    if (got_q.size() < 3 || got_q[2][63:16] !== 48'h0) begin
      n_fail++; $display("FAIL flush_upper_zero: got %h want upper 48 bits zero", (got_q.size() > 2) ? got_q[2] : 64'hx);
    end
  endtask

  task automatic test_zero_frame();
    bit ok;
    int waited, rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_params(16'd0, 32'd5, ok, waited);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_ready: got 0 want 1"); end
    @(negedge clk);
    n_checks++; if (bus.ap_idle !== 1'b0) begin n_fail++; $display("FAIL zero_busy_idle: got %b want 0", bus.ap_idle); end
    @(posedge clk); #1;
    finish_frame(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done: got timeout want ap_done"); end
    n_checks++;
    if (rd_cnt != rd0 || wr_cnt != wr0) begin
      n_fail++; $display("FAIL zero_traffic: got reads=%0d writes=%0d want 0/0", rd_cnt - rd0, wr_cnt - wr0);
    end
    @(negedge clk);
    n_checks++; if (bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL zero_idle_back: got %b want 1", bus.ap_idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    int waited, r, c;
    int rs[4], cs[4];
    exp_q.delete(); got_q.delete();
    rand_in = 1'b1; rand_out = 1'b1;
    push_params(16'd0, 32'd1, ok, waited);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ap_done) seen = 1'b1;
      @(posedge clk); #1;
      if (seen) break;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_hold_done: got timeout want ap_done"); end
    for (int k = 0; k < 4; k++) begin
      rs[k] = $urandom_range(1, 3);
      cs[k] = $urandom_range(1, 10);
      add_frame(rs[k], cs[k], 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      push_params(16'(rs[k]), 32'(cs[k]), ok, waited);
      n_checks++;
      if (!ok || waited != 0) begin n_fail++; $display("FAIL b2b_ready%0d: got ok=%0d wait=%0d want ok=1 wait=0", k, ok, waited); end
    end
    r = rs[3]; c = cs[3];
    bus.ap_start = 1'b1; bus.rows = 16'(r); bus.cols = 32'(c);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (bus.ap_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_stall%0d: got %b want 0", i, bus.ap_ready); end
      @(posedge clk); #1;
    end
    bus.ap_continue = 1'b1;
    @(posedge clk); #1;
    bus.ap_continue = 1'b0;
    push_params(16'(r), 32'(c), ok, waited);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_ready3: got 0 want 1 after pop"); end
    for (int k = 0; k < 4; k++) begin
      finish_frame(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done%0d: got timeout want ap_done", k); end
    end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
      end
    end
    n_checks++; if (pix_q.size() != 0) begin n_fail++; $display("FAIL b2b_pixels_left: got %0d want 0", pix_q.size()); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL b2b_protocol: got %0d violations want 0", viol); end
    rand_in = 1'b0; rand_out = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit ok, hit;
    int waited, rd0;
    exp_q.delete(); got_q.delete();
    rd0 = rd_cnt;
    add_frame(4, 10, 1'b0);
    push_params(16'd4, 32'd10, ok, waited);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rd_cnt - rd0 >= 5) begin hit = 1'b1; break; end
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_mid_progress: got %0d reads want >=5", rd_cnt - rd0); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.in_read !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_read: got %b want 0", bus.in_read); end
    n_checks++; if (bus.out_write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_write: got %b want 0", bus.out_write); end
    n_checks++; if (bus.out_din !== 64'h0) begin n_fail++; $display("FAIL rst_mid_out_din: got %h want 0", bus.out_din); end
    n_checks++; if (bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ap_idle: got %b want 1", bus.ap_idle); end
    n_checks++; if (bus.ap_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ap_done: got %b want 0", bus.ap_done); end
    n_checks++; if (bus.ap_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ap_ready: got %b want 0", bus.ap_ready); end
    @(posedge clk); #1;
    pix_q.delete(); exp_q.delete(); got_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    add_frame(1, 8, 1'b0);
    push_params(16'd1, 32'd8, ok, waited);
    finish_frame(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_new_done: got timeout want ap_done"); end
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL rst_new_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rst_new_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.ap_start    = 1'b0;
    bus.ap_continue = 1'b0;
    bus.rows        = '0;
    bus.cols        = '0;
    test_reset();
    test_small_frame();
    test_single_pixel();
    test_flush_word();
    test_zero_frame();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
